// File: rtl/led_seq_pkg.sv
// Shared definitions for the Avalon LED pattern sequencer: register map, modes, FSM states.
package led_seq_pkg;

  // s0 register offsets
  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_PERIOD = 1;
  localparam int unsigned REG_SEED   = 2;
  localparam int unsigned REG_STATUS = 3;

  // CTRL / STATUS bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_MODE_LSB   = 1;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_ERR_BIT  = 1;
  localparam int unsigned STATUS_PAT_LSB  = 8;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step prescaler: counts clock cycles while enabled and flags the last cycle of each period.
module led_seq_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] period_i,
  output logic        tick_c_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] limit;

  // A period of 0 behaves like a period of 1 (tick every cycle)
  assign limit    = (period_i == 32'd0) ? 32'd0 : period_i - 32'd1;
  assign tick_c_o = en_i && (cnt_q == limit);

  // Next count: held at 0 while disabled or cleared, wraps after the tick
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i || tick_c_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_led_sequencer.sv
// Avalon-MM LED pattern sequencer: configured through slave s0, pushes each pattern to the
// LED peripheral through master m0. Optional read-back check enabled by LED_SEQ_READBACK_EN.
module avalon_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned LED_W      = 8,
  parameter int unsigned M_ADDR_W   = 1,
  parameter int unsigned LED_ADDR   = 0,
  parameter int unsigned PERIOD_RST = 50_000_000
) (
  input  logic                clock_clk,
  input  logic                reset_reset_n,
  input  logic [1:0]          avs_s0_address,
  input  logic                avs_s0_read,
  output logic [31:0]         avs_s0_readdata,
  input  logic                avs_s0_write,
  input  logic [31:0]         avs_s0_writedata,
  output logic                avs_s0_waitrequest,
  output logic [M_ADDR_W-1:0] avm_m0_address,
  output logic                avm_m0_write,
  output logic [31:0]         avm_m0_writedata,
  output logic                avm_m0_read,
  input  logic [31:0]         avm_m0_readdata,
  input  logic                avm_m0_waitrequest
);

  logic             en_q, en_d;
  mode_e            mode_q, mode_d;
  logic [31:0]      period_q, period_d;
  logic [LED_W-1:0] seed_q, seed_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic             phase_q, phase_d;
  logic             pend_q, pend_d;
  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic             read_q, read_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;

  logic  wr_ctrl, wr_period, wr_seed, wr_status;
  logic  new_en;
  mode_e new_mode;
  logic  seed_load, tick, start_wr;
  logic  unused_ok;

  assign wr_ctrl   = avs_s0_write && (avs_s0_address == 2'(REG_CTRL));
  assign wr_period = avs_s0_write && (avs_s0_address == 2'(REG_PERIOD));
  assign wr_seed   = avs_s0_write && (avs_s0_address == 2'(REG_SEED));
  assign wr_status = avs_s0_write && (avs_s0_address == 2'(REG_STATUS));
  assign new_en    = avs_s0_writedata[CTRL_EN_BIT];
  assign new_mode  = mode_e'(avs_s0_writedata[CTRL_MODE_LSB +: 2]);

  assign avs_s0_waitrequest = 1'b0;
  assign avm_m0_address     = M_ADDR_W'(LED_ADDR);
  assign avm_m0_write       = write_q;
  assign avm_m0_read        = read_q;
  assign avm_m0_writedata   = wdata_q;
  assign unused_ok          = ^{avs_s0_read, avm_m0_readdata};

  led_seq_prescaler u_prescaler (
    .clk      (clock_clk),
    .rst_n    (reset_reset_n),
    .en_i     (en_q),
    .clr_i    (wr_period),
    .period_i (period_q),
    .tick_c_o (tick)
  );

  // Config read mux; data is valid in the same cycle as the read
  always_comb begin
    avs_s0_readdata = '0;
    case (avs_s0_address)
      2'(REG_CTRL): begin
        avs_s0_readdata[CTRL_EN_BIT]        = en_q;
        avs_s0_readdata[CTRL_MODE_LSB +: 2] = mode_q;
      end
      2'(REG_PERIOD): avs_s0_readdata = period_q;
      2'(REG_SEED):   avs_s0_readdata = 32'(seed_q);
      default: begin
        avs_s0_readdata[STATUS_BUSY_BIT]     = (state_q != ST_IDLE);
        avs_s0_readdata[STATUS_ERR_BIT]      = err_q;
        avs_s0_readdata[STATUS_PAT_LSB +: 8] = 8'(pat_q);
      end
    endcase
  end

  // Config registers, pattern stepping, pending flag and master FSM next state
  always_comb begin
    en_d     = wr_ctrl ? new_en : en_q;
    mode_d   = wr_ctrl ? new_mode : mode_q;
    period_d = wr_period ? avs_s0_writedata : period_q;
    seed_d   = wr_seed ? avs_s0_writedata[LED_W-1:0] : seed_q;
    pat_d    = pat_q;
    phase_d  = phase_q;
    pend_d   = pend_q;
    state_d  = state_q;
    write_d  = write_q;
    read_d   = read_q;
    wdata_d  = wdata_q;
    err_d    = err_q;

    seed_load = (wr_ctrl && new_en && (!en_q || (new_mode != mode_q))) ||
                (wr_seed && en_q);
    start_wr  = (state_q == ST_IDLE) && pend_q && en_q;

    // Seed load wins over a coincident tick; the tick step uses the pre-write mode
    if (seed_load) begin
      pat_d   = seed_d;
      phase_d = 1'b1;
    end else if (tick) begin
      case (mode_q)
        MODE_STATIC: pat_d = seed_q;
        MODE_BLINK: begin
          pat_d   = phase_q ? '0 : seed_q;
          phase_d = ~phase_q;
        end
        MODE_WALK:  pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        default:    pat_d = pat_q + LED_W'(1);
      endcase
    end

    if (wr_status && avs_s0_writedata[STATUS_ERR_BIT]) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          state_d = ST_WR;
          write_d = 1'b1;
          wdata_d = 32'(pat_q);
        end
      end
      ST_WR: begin
        if (!avm_m0_waitrequest) begin
          write_d = 1'b0;
`ifdef LED_SEQ_READBACK_EN
          state_d = ST_RD;
          read_d  = 1'b1;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_RD: begin
`ifdef LED_SEQ_READBACK_EN
        if (!avm_m0_waitrequest) begin
          read_d  = 1'b0;
          state_d = ST_IDLE;
          if (avm_m0_readdata[LED_W-1:0] != wdata_q[LED_W-1:0]) begin
            err_d = 1'b1;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // One-deep pending: a new step during entry re-arms it; disabling drops it
    if (start_wr) begin
      pend_d = 1'b0;
    end
    if (seed_load || tick) begin
      pend_d = 1'b1;
    end
    if (!en_d) begin
      pend_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_STATIC;
      period_q <= 32'(PERIOD_RST);
      seed_q   <= '0;
      pat_q    <= '0;
      phase_q  <= 1'b0;
      pend_q   <= 1'b0;
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      seed_q   <= seed_d;
      pat_q    <= pat_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      write_q  <= write_d;
      read_q   <= read_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_avalon_led_sequencer.sv
// Self-checking bench for avalon_led_sequencer: scoreboard of expected m0 writes per scenario.
`timescale 1ns/1ps
module tb_avalon_led_sequencer;

  localparam int unsigned PERIOD_RST = 50_000_000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_addr;
  logic        s_read, s_write, s_wait;
  logic [31:0] s_rdata, s_wdata;
  logic [0:0]  m_addr;
  logic        m_write, m_read, m_wait;
  logic [31:0] m_wdata, m_rdata;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc_n = 0;

  logic [31:0] got_d[$];
  int          got_c[$];
  logic [31:0] exp_q[$];
  bit          unstable, timed_out;

  avalon_led_sequencer dut (
    .clock_clk          (clk),
    .reset_reset_n      (rst_n),
    .avs_s0_address     (s_addr),
    .avs_s0_read        (s_read),
    .avs_s0_readdata    (s_rdata),
    .avs_s0_write       (s_write),
    .avs_s0_writedata   (s_wdata),
    .avs_s0_waitrequest (s_wait),
    .avm_m0_address     (m_addr),
    .avm_m0_write       (m_write),
    .avm_m0_writedata   (m_wdata),
    .avm_m0_read        (m_read),
    .avm_m0_readdata    (m_rdata),
    .avm_m0_waitrequest (m_wait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    s_addr  = '0;
    s_read  = 1'b0;
    s_write = 1'b0;
    s_wdata = '0;
    m_wait  = 1'b0;
    m_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic s0_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    s_addr  = a;
    s_wdata = d;
    s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic s0_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    s_addr = a;
    s_read = 1'b1;
    #1 d = s_rdata;
    s_read = 1'b0;
  endtask

  // Act as the LED slave: stall each write for 'stall' cycles, record accepted data and start cycle
  task automatic collect(input int n, input int stall, input int budget);
    int cyc = 0;
    int sc  = 0;
    int start_c = 0;
    logic [31:0] first_wd = '0;
    got_d.delete();
    got_c.delete();
    unstable  = 1'b0;
    timed_out = 1'b0;
    while (got_d.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (m_write) begin
        if (sc == 0) begin
          first_wd = m_wdata;
          start_c  = int'(cyc_n);
        end else if (m_wdata !== first_wd) begin
          unstable = 1'b1;
        end
        if (sc < stall) begin
          m_wait = 1'b1;
          sc++;
        end else begin
          m_wait = 1'b0;
          sc = 0;
          got_d.push_back(m_wdata);
          got_c.push_back(start_c);
        end
      end else begin
        m_wait = 1'b0;
        sc = 0;
      end
    end
    m_wait = 1'b0;
    if (got_d.size() < n) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bit seen;
    do_reset();
    checks++; if (m_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0h exp=0", m_write); end
    checks++; if (m_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%0h exp=0", m_read); end
    checks++; if (m_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%0h exp=0", m_wdata); end
    checks++; if (s_wait !== 1'b0) begin failures++; $display("FAIL s0_waitrequest got=%0h exp=0", s_wait); end
    s0_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%0h exp=0", rd); end
    s0_read(2'd1, rd);
    checks++; if (rd !== 32'(PERIOD_RST)) begin failures++; $display("FAIL rst_period got=%0d exp=%0d", rd, PERIOD_RST); end
    s0_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_status got=%0h exp=0", rd); end
    // Start a transfer, hold it stalled, then reset in the middle of the cycle
    m_wait = 1'b1;
    s0_write(2'd2, 32'hAA);
    s0_write(2'd1, 32'd4);
    s0_write(2'd0, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_write;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rst_wr_start got=%0b exp=1", seen); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_write !== 1'b0) begin failures++; $display("FAIL rst_async_write got=%0h exp=0", m_write); end
    checks++; if (m_wdata !== 32'h0) begin failures++; $display("FAIL rst_async_wdata got=%0h exp=0", m_wdata); end
    m_wait = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s0_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_mid_status got=%0h exp=0", rd); end
    s0_read(2'd1, rd);
    checks++; if (rd !== 32'(PERIOD_RST)) begin failures++; $display("FAIL rst_mid_period got=%0d exp=%0d", rd, PERIOD_RST); end
  endtask

  task automatic test_count();
    logic [31:0] e, g;
    do_reset();
    s0_write(2'd2, 32'hFE);
    s0_write(2'd1, 32'd4);
    s0_write(2'd0, 32'h7);
    exp_q.push_back(32'hFE); exp_q.push_back(32'hFF);
    exp_q.push_back(32'h00); exp_q.push_back(32'h01);
    collect(4, 0, 60);
    checks++; if (timed_out) begin failures++; $display("FAIL count_timeout got=%0d exp=4 writes", got_d.size()); end
    for (int i = 1; i < got_c.size(); i++) begin
      checks++;
      if (got_c[i] - got_c[i-1] != 4) begin
        failures++; $display("FAIL count_spacing[%0d] got=%0d exp=4", i, got_c[i] - got_c[i-1]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_d.size() > 0) ? got_d.pop_front() : 32'hxxxxxxxx;
      checks++; if (g !== e) begin failures++; $display("FAIL count_data got=%0h exp=%0h", g, e); end
    end
  endtask

  task automatic test_walk_stall();
    logic [31:0] e, g;
    int en_cyc;
    do_reset();
    s0_write(2'd2, 32'h81);
    s0_write(2'd1, 32'd1);
    s0_write(2'd0, 32'h5);
    en_cyc = int'(cyc_n);
    collect(4, 3, 80);
    checks++; if (timed_out) begin failures++; $display("FAIL walk_timeout got=%0d exp=4 writes", got_d.size()); end
    checks++; if (unstable) begin failures++; $display("FAIL walk_stable got=unstable exp=stable"); end
    // Pattern rotates once per cycle; each write carries the pattern current at its start
    for (int i = 0; i < got_c.size(); i++) exp_q.push_back(32'(rotl8(8'h81, got_c[i] - en_cyc - 1)));
    checks++; if (got_c.size() > 0 && got_c[0] - en_cyc != 1) begin
      failures++; $display("FAIL walk_first_start got=%0d exp=1", got_c[0] - en_cyc);
    end
    for (int i = 1; i < got_c.size(); i++) begin
      checks++;
      if (got_c[i] - got_c[i-1] != 5) begin
        failures++; $display("FAIL walk_spacing[%0d] got=%0d exp=5", i, got_c[i] - got_c[i-1]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_d.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL walk_data got=%0h exp=%0h", g, e); end
    end
  endtask

  task automatic test_blink_en_clear();
    logic [31:0] e, g;
    bit seen;
    bit prev;
    int starts;
    do_reset();
    s0_write(2'd2, 32'h5A);
    s0_write(2'd1, 32'd4);
    s0_write(2'd0, 32'h3);
    exp_q.push_back(32'h5A); exp_q.push_back(32'h00); exp_q.push_back(32'h5A);
    collect(3, 0, 60);
    checks++; if (timed_out) begin failures++; $display("FAIL blink_timeout got=%0d exp=3 writes", got_d.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_d.size() > 0) ? got_d.pop_front() : 32'hxxxxxxxx;
      checks++; if (g !== e) begin failures++; $display("FAIL blink_data got=%0h exp=%0h", g, e); end
    end
    @(negedge clk);
    m_wait = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_write;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL blink_4th_start got=%0b exp=1", seen); end
    s0_write(2'd0, 32'h2);
    checks++; if (m_write !== 1'b1) begin failures++; $display("FAIL blink_hold_write got=%0b exp=1", m_write); end
    checks++; if (m_wdata !== 32'h00) begin failures++; $display("FAIL blink_hold_data got=%0h exp=0", m_wdata); end
    m_wait = 1'b0;
    prev = 1'b1;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_write && !prev) starts++;
      prev = m_write;
    end
    checks++; if (starts != 0) begin failures++; $display("FAIL blink_after_disable got=%0d exp=0 writes", starts); end
  endtask

  task automatic test_period0_simul();
    logic [31:0] e, g;
    do_reset();
    s0_write(2'd2, 32'h10);
    s0_write(2'd1, 32'd0);
    s0_write(2'd0, 32'h7);
    exp_q.push_back(32'h10); exp_q.push_back(32'h12);
    exp_q.push_back(32'h14); exp_q.push_back(32'h16);
    collect(4, 0, 40);
    checks++; if (timed_out) begin failures++; $display("FAIL p0_timeout got=%0d exp=4 writes", got_d.size()); end
    for (int i = 1; i < got_c.size(); i++) begin
      checks++;
      if (got_c[i] - got_c[i-1] != 2) begin
        failures++; $display("FAIL p0_spacing[%0d] got=%0d exp=2", i, got_c[i] - got_c[i-1]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_d.size() > 0) ? got_d.pop_front() : 32'hxxxxxxxx;
      checks++; if (g !== e) begin failures++; $display("FAIL p0_data got=%0h exp=%0h", g, e); end
    end
    // SEED write lands on the same edge as the fourth-cycle tick
    do_reset();
    s0_write(2'd2, 32'h20);
    s0_write(2'd1, 32'd4);
    s0_write(2'd0, 32'h7);
    exp_q.push_back(32'h20); exp_q.push_back(32'h40); exp_q.push_back(32'h41);
    fork
      collect(3, 0, 60);
      begin
        repeat (2) @(negedge clk);
        s0_write(2'd2, 32'h40);
      end
    join
    checks++; if (timed_out) begin failures++; $display("FAIL simul_timeout got=%0d exp=3 writes", got_d.size()); end
    checks++; if (got_c.size() == 3 && got_c[2] - got_c[1] != 4) begin
      failures++; $display("FAIL simul_spacing got=%0d exp=4", got_c[2] - got_c[1]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_d.size() > 0) ? got_d.pop_front() : 32'hxxxxxxxx;
      checks++; if (g !== e) begin failures++; $display("FAIL simul_data got=%0h exp=%0h", g, e); end
    end
  endtask

  task automatic test_readback();
    logic [31:0] rd, g;
    bit rd_seen;
    do_reset();
    m_rdata = 32'h0;
    s0_write(2'd2, 32'h3C);
    s0_write(2'd1, 32'd100);
    s0_write(2'd0, 32'h1);
    exp_q.push_back(32'h3C);
    collect(1, 0, 20);
    checks++; if (timed_out) begin failures++; $display("FAIL rb_timeout got=%0d exp=1 writes", got_d.size()); end
    g = (got_d.size() > 0) ? got_d.pop_front() : 32'hxxxxxxxx;
    rd = exp_q.pop_front();
    checks++; if (g !== rd) begin failures++; $display("FAIL rb_data got=%0h exp=%0h", g, rd); end
    rd_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_read) rd_seen = 1'b1;
    end
    s0_read(2'd3, rd);
    checks++; if (rd[15:8] !== 8'h3C) begin failures++; $display("FAIL rb_status_pat got=%0h exp=3c", rd[15:8]); end
`ifdef LED_SEQ_READBACK_EN
    checks++; if (rd_seen !== 1'b1) begin failures++; $display("FAIL rb_read_strobe got=%0b exp=1", rd_seen); end
    checks++; if (rd[1] !== 1'b1) begin failures++; $display("FAIL rb_err_set got=%0b exp=1", rd[1]); end
    s0_write(2'd3, 32'h2);
    s0_read(2'd3, rd);
    checks++; if (rd[1] !== 1'b0) begin failures++; $display("FAIL rb_err_w1c got=%0b exp=0", rd[1]); end
    m_rdata = 32'h3C;
    s0_write(2'd2, 32'h3C);
    collect(1, 0, 20);
    checks++; if (timed_out) begin failures++; $display("FAIL rb_match_timeout got=%0d exp=1 writes", got_d.size()); end
    repeat (4) @(negedge clk);
    s0_read(2'd3, rd);
    checks++; if (rd[1] !== 1'b0) begin failures++; $display("FAIL rb_err_match got=%0b exp=0", rd[1]); end
`else
    checks++; if (rd_seen !== 1'b0) begin failures++; $display("FAIL rb_read_strobe got=%0b exp=0", rd_seen); end
    checks++; if (rd[1] !== 1'b0) begin failures++; $display("FAIL rb_err_off got=%0b exp=0", rd[1]); end
    checks++; if (rd[0] !== 1'b0) begin failures++; $display("FAIL rb_busy got=%0b exp=0", rd[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_count();
    test_walk_stall();
    test_blink_en_clear();
    test_period0_simul();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
